// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-register I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR_W,
    ST_IDX,
    ST_DATA_W,
    ST_RESTART,
    ST_ADDR_R,
    ST_DATA_R,
    ST_STOP,
    ST_DONE
  } i2c_mst_state_t;

  localparam logic       I2C_RW_WRITE     = 1'b0;
  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h5D;
  localparam logic [3:0] ACK_BIT          = 4'd8;

  function automatic logic is_byte_state(input i2c_mst_state_t s);
    return (s == ST_ADDR_W) || (s == ST_IDX) || (s == ST_DATA_W) ||
           (s == ST_ADDR_R) || (s == ST_DATA_R);
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit timer: down-counter reloading every CLK_DIV cycles, with a 2-bit phase index.
module i2c_phase_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       quarter_tick,
  output logic [1:0] phase
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign quarter_tick = (cnt == '0);

  // start realigns the phase so every transaction begins on a fresh q0
  always_ff @(posedge CLK) begin
    if (RST || start) begin
      cnt   <= RELOAD;
      phase <= 2'd0;
    end else if (quarter_tick) begin
      cnt   <= RELOAD;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// Command-driven I2C master for single-register write/read on 7-bit slaves.
// state   | meaning
// IDLE    | bus released, CMD_READY high
// START   | start condition from idle bus
// ADDR_W  | address byte with write bit
// IDX     | register index byte
// DATA_W  | write data byte
// RESTART | repeated start before read address
// ADDR_R  | address byte with read bit
// DATA_R  | read data byte, master NACKs
// STOP    | stop condition
// DONE    | one-cycle response pulse
module i2c_reg_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_RW,
  input  logic [6:0] CMD_DEV,
  input  logic [7:0] CMD_IDX,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       SCL_o,
  output logic       SDA_o,
  input  logic       SDA_i
);

  i2c_mst_state_t state, state_next;
  logic       ready_q, rw_q, nack_q, err_q, rsp_err_q;
  logic [6:0] dev_q;
  logic [7:0] idx_q, wdata_q, rx_sh, rsp_rdata_q, tx_byte;
  logic [3:0] bit_cnt;
  logic [1:0] phase;
  logic       quarter_tick, handshake, sample, bit_end, byte_done;

  assign handshake = CMD_VALID && ready_q;
  assign sample    = quarter_tick && (phase == 2'd2);
  assign bit_end   = quarter_tick && (phase == 2'd3);
  assign byte_done = bit_end && (bit_cnt == ACK_BIT);

  assign CMD_READY = ready_q;
  assign RSP_VALID = (state == ST_DONE);
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

  i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .CLK          (CLK),
    .RST          (RST),
    .start        (handshake),
    .quarter_tick (quarter_tick),
    .phase        (phase)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (handshake) state_next = ST_START;
      ST_START:   if (bit_end) state_next = ST_ADDR_W;
      ST_ADDR_W:  if (byte_done) state_next = nack_q ? ST_STOP : ST_IDX;
      ST_IDX:     if (byte_done) state_next = nack_q ? ST_STOP :
                                 (rw_q == I2C_RW_READ) ? ST_RESTART : ST_DATA_W;
      ST_DATA_W:  if (byte_done) state_next = ST_STOP;
      ST_RESTART: if (bit_end) state_next = ST_ADDR_R;
      ST_ADDR_R:  if (byte_done) state_next = nack_q ? ST_STOP : ST_DATA_R;
      ST_DATA_R:  if (byte_done) state_next = ST_STOP;
      ST_STOP:    if (bit_end) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      ST_ADDR_W: tx_byte = {dev_q, I2C_RW_WRITE};
      ST_IDX:    tx_byte = idx_q;
      ST_DATA_W: tx_byte = wdata_q;
      ST_ADDR_R: tx_byte = {dev_q, I2C_RW_READ};
      default:   tx_byte = 8'hFF;
    endcase
  end

  // SDA only moves together with or after SCL falling, except in START/RESTART/STOP
  always_comb begin
    SCL_o = 1'b1;
    SDA_o = 1'b1;
    case (state)
      ST_START: begin
        SCL_o = (phase != 2'd3);
        SDA_o = ~phase[1];
      end
      ST_RESTART: begin
        SCL_o = phase[1] ^ phase[0];
        SDA_o = ~phase[1];
      end
      ST_STOP: begin
        SCL_o = (phase != 2'd0);
        SDA_o = phase[1];
      end
      ST_ADDR_W, ST_IDX, ST_DATA_W, ST_ADDR_R, ST_DATA_R: begin
        SCL_o = phase[1];
        SDA_o = (bit_cnt == ACK_BIT) ? 1'b1 : tx_byte[~bit_cnt[2:0]];
      end
      default: begin
        SCL_o = 1'b1;
        SDA_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      rw_q        <= I2C_RW_WRITE;
      dev_q       <= 7'h00;
      idx_q       <= 8'h00;
      wdata_q     <= 8'h00;
      bit_cnt     <= 4'd0;
      rx_sh       <= 8'h00;
      nack_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_IDLE);
      if (handshake) begin
        rw_q    <= CMD_RW;
        dev_q   <= CMD_DEV;
        idx_q   <= CMD_IDX;
        wdata_q <= CMD_WDATA;
        err_q   <= 1'b0;
      end
      if (sample && is_byte_state(state)) begin
        if (bit_cnt == ACK_BIT) nack_q <= SDA_i;
        else if (state == ST_DATA_R) rx_sh <= {rx_sh[6:0], SDA_i};
      end
      if (bit_end && is_byte_state(state))
        bit_cnt <= (bit_cnt == ACK_BIT) ? 4'd0 : bit_cnt + 4'd1;
      // the master's own NACK on the read byte is not an error
      if (byte_done && nack_q && (state != ST_DATA_R)) err_q <= 1'b1;
      if ((state == ST_STOP) && bit_end) begin
        rsp_err_q   <= err_q;
        rsp_rdata_q <= (err_q || (rw_q == I2C_RW_WRITE)) ? 8'h00 : rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Self-checking bench: bus-level slave model plus transaction-level reference model.
module tb_i2c_reg_master;

  localparam int         CLK_DIV    = 1;
  localparam logic [6:0] SLV_DEV    = 7'h5D;
  localparam int         TXN_BUDGET = 50 * 4 * CLK_DIV + 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic       CMD_RW = 1'b0;
  logic [6:0] CMD_DEV = 7'h00;
  logic [7:0] CMD_IDX = 8'h00;
  logic [7:0] CMD_WDATA = 8'h00;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RSP_ERR;
  logic       SCL_o, SDA_o, SDA_i;
  logic       slv_sda = 1'b1;

  assign SDA_i = SDA_o & slv_sda;

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_RW(CMD_RW), .CMD_DEV(CMD_DEV), .CMD_IDX(CMD_IDX), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .SCL_o(SCL_o), .SDA_o(SDA_o), .SDA_i(SDA_i)
  );

  always #5 CLK = ~CLK;

  // bus monitor and slave model, evaluated mid-cycle
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         n_start = 0, n_stop = 0, rsp_cnt = 0, mon_bits = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [8:0] bus_log [$];
  logic       s_active = 1'b0, s_rd_pend = 1'b0, s_rd_tx = 1'b0;
  int         s_bit = 0, s_byte = 0;
  logic [7:0] s_sh = 8'h00, s_ptr = 8'h00, s_tx = 8'h00;
  logic [7:0] slv_regs [256] = '{default: 8'h00};

  always @(negedge CLK) begin
    prev_scl <= SCL_o;
    prev_sda <= SDA_i;
    if (RSP_VALID) rsp_cnt <= rsp_cnt + 1;
    if (prev_scl && SCL_o && prev_sda && !SDA_i) begin
      n_start   <= n_start + 1;
      mon_bits  <= 0;
      s_active  <= 1'b1;
      s_bit     <= 0;
      s_byte    <= 0;
      s_rd_pend <= 1'b0;
      s_rd_tx   <= 1'b0;
      slv_sda   <= 1'b1;
    end else if (prev_scl && SCL_o && !prev_sda && SDA_i) begin
      n_stop   <= n_stop + 1;
      s_active <= 1'b0;
      s_rd_tx  <= 1'b0;
      slv_sda  <= 1'b1;
    end else if (!prev_scl && SCL_o) begin
      if (mon_bits == 8) begin
        bus_log.push_back({mon_sh, SDA_i});
        mon_bits <= 0;
      end else begin
        mon_sh   <= {mon_sh[6:0], SDA_i};
        mon_bits <= mon_bits + 1;
      end
      if (s_active) begin
        if (!s_rd_tx && s_bit < 8) s_sh <= {s_sh[6:0], SDA_i};
        s_bit <= s_bit + 1;
      end
    end else if (prev_scl && !SCL_o && s_active) begin
      if (s_bit == 8) begin
        if (s_rd_tx) slv_sda <= 1'b1;
        else if (s_byte == 0) begin
          if (s_sh[7:1] == SLV_DEV) begin
            slv_sda   <= 1'b0;
            s_rd_pend <= s_sh[0];
            s_tx      <= slv_regs[s_ptr];
          end else s_active <= 1'b0;
        end else if (s_byte == 1) begin
          s_ptr   <= s_sh;
          slv_sda <= 1'b0;
        end else begin
          slv_regs[s_ptr] <= s_sh;
          slv_sda         <= 1'b0;
        end
      end else if (s_bit == 9) begin
        s_bit  <= 0;
        s_byte <= s_byte + 1;
        if (s_rd_pend) begin
          s_rd_pend <= 1'b0;
          s_rd_tx   <= 1'b1;
          slv_sda   <= s_tx[7];
        end else begin
          s_rd_tx <= 1'b0;
          slv_sda <= 1'b1;
        end
      end else if (s_rd_tx && s_bit < 8) begin
        slv_sda <= s_tx[7 - s_bit];
      end
    end
  end

  int         checks = 0, errors = 0;
  logic [7:0] ref_regs [256] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] idx,
                       input logic [7:0] wd);
    int w = 0;
    CMD_RW = rw; CMD_DEV = dev; CMD_IDX = idx; CMD_WDATA = wd; CMD_VALID = 1'b1;
    while (!CMD_READY && w < 20) begin @(posedge CLK); #1; w++; end
    check("cmd_ready_wait", CMD_READY, 1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    check("ready_drop", CMD_READY, 0);
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] idx,
                         input logic [7:0] wd);
    logic [8:0] exp_log [$];
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_starts, exp_lat, base, st0, sp0, n;
    exp_lat = -1;
    exp_starts = 1;
    exp_err = 1'b0;
    exp_rd = 8'h00;
    exp_log.push_back({dev, 1'b0, (dev == SLV_DEV) ? 1'b0 : 1'b1});
    if (dev != SLV_DEV) begin
      exp_err = 1'b1;
      exp_lat = (1 + 9 + 1) * 4 * CLK_DIV;
    end else if (!rw) begin
      exp_log.push_back({idx, 1'b0});
      exp_log.push_back({wd, 1'b0});
      ref_regs[idx] = wd;
      exp_lat = 29 * 4 * CLK_DIV;
    end else begin
      exp_log.push_back({idx, 1'b0});
      exp_log.push_back({dev, 1'b1, 1'b0});
      exp_log.push_back({ref_regs[idx], 1'b1});
      exp_rd = ref_regs[idx];
      exp_starts = 2;
    end
    base = bus_log.size(); st0 = n_start; sp0 = n_stop;
    issue(rw, dev, idx, wd);
    n = 0;
    while (!RSP_VALID && n < TXN_BUDGET) begin @(posedge CLK); #1; n++; end
    check("rsp_valid", RSP_VALID, 1);
    if (exp_lat >= 0) check("latency", n, exp_lat);
    check("rsp_err", RSP_ERR, exp_err);
    check("rsp_rdata", RSP_RDATA, exp_rd);
    @(posedge CLK); #1;
    check("rsp_pulse", RSP_VALID, 0);
    check("ready_back", CMD_READY, 1);
    check("rsp_hold", RSP_RDATA, exp_rd);
    check("log_len", bus_log.size() - base, exp_log.size());
    for (int i = 0; i < exp_log.size() && base + i < bus_log.size(); i++)
      check($sformatf("log_byte%0d", i), bus_log[base + i], exp_log[i]);
    check("starts", n_start - st0, exp_starts);
    check("stops", n_stop - sp0, 1);
  endtask

  initial begin
    int r0, n, ready_bad;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_scl", SCL_o, 1);
    check("rst_sda", SDA_o, 1);
    check("rst_ready", CMD_READY, 0);
    check("rst_valid", RSP_VALID, 0);
    check("rst_rdata", RSP_RDATA, 0);
    check("rst_err", RSP_ERR, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_after_rst", CMD_READY, 1);

    run_txn(1'b0, 7'h5D, 8'h03, 8'h57);
    run_txn(1'b1, 7'h5D, 8'h03, 8'h00);
    check("slave_reg03", slv_regs[3], 8'h57);
    run_txn(1'b0, 7'h22, 8'h03, 8'h99);

    // abort during ADDR_W bit 4, quarter 1
    r0 = rsp_cnt;
    issue(1'b0, 7'h5D, 8'h04, 8'hC3);
    repeat (21 * CLK_DIV) @(posedge CLK);
    #1;
    check("pre_rst_scl", SCL_o, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_scl", SCL_o, 1);
    check("abort_sda", SDA_o, 1);
    check("abort_valid", RSP_VALID, 0);
    check("abort_ready", CMD_READY, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("abort_ready_back", CMD_READY, 1);
    repeat (4) @(posedge CLK);
    #1;
    check("abort_no_rsp", rsp_cnt - r0, 0);

    // second command held while busy
    r0 = rsp_cnt;
    issue(1'b0, 7'h5D, 8'h10, 8'hA5);
    ref_regs[8'h10] = 8'hA5;
    CMD_RW = 1'b1; CMD_DEV = 7'h5D; CMD_IDX = 8'h10; CMD_WDATA = 8'h11; CMD_VALID = 1'b1;
    n = 0; ready_bad = 0;
    while (!RSP_VALID && n < TXN_BUDGET) begin
      if (CMD_READY) ready_bad++;
      @(posedge CLK); #1; n++;
    end
    check("busy_ready_low", ready_bad, 0);
    check("busy_first_rsp", RSP_VALID, 1);
    check("busy_first_err", RSP_ERR, 0);
    check("busy_ready_in_done", CMD_READY, 0);
    n = 0;
    while (!CMD_READY && n < 10) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    n = 0;
    while (!RSP_VALID && n < TXN_BUDGET) begin @(posedge CLK); #1; n++; end
    check("busy_second_rsp", RSP_VALID, 1);
    check("busy_second_rdata", RSP_RDATA, 8'hA5);
    repeat (10) @(posedge CLK);
    #1;
    check("busy_rsp_count", rsp_cnt - r0, 2);

    for (int t = 0; t < 16; t++) begin
      logic [6:0] dev;
      dev = SLV_DEV;
      if ($urandom_range(0, 3) == 0) begin
        dev = 7'($urandom_range(0, 127));
        if (dev == SLV_DEV) dev = 7'h22;
      end
      run_txn(1'($urandom_range(0, 1)), dev, 8'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
